// File: rtl/regfile_decode.sv
// regfile_decode: register file, bypass, pending-write scoreboard and RV32 immediates behind a valid/ready output register.
module regfile_decode #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [2:0]            ImmControl,
  input  logic                  in_rd_we,
  input  logic                  RegWrite,
  input  logic [AW-1:0]         a3,
  input  logic [XLEN-1:0]       wd3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2,
  output logic [XLEN-1:0]       ImmOp,
  output logic [AW-1:0]         out_rd,
  output logic                  out_rd_we,
  output logic [(1<<AW)-1:0]    busy
);
  localparam int NREGS = 1 << AW;
  logic [XLEN-1:0]  regs [NREGS];
  logic [AW-1:0]    rs1, rs2, rd;
  logic             wr_en, hazard, acc;
  logic [XLEN-1:0]  op1, op2, imm;
  logic [31:0]      imm32;
  logic [NREGS-1:0] busy_nxt;
  logic             unused_opcode;
  assign unused_opcode = ^instr[6:0];
  assign rs1   = instr[15 +: AW];
  assign rs2   = instr[20 +: AW];
  assign rd    = instr[7 +: AW];
  assign wr_en = RegWrite && a3 != '0;
  // regs[0] is never written, so reading it already yields zero
  assign op1 = (wr_en && a3 == rs1) ? wd3 : regs[rs1];
  assign op2 = (wr_en && a3 == rs2) ? wd3 : regs[rs2];
  // a source landing in this cycle's writeback is bypassed, not stalled
  assign hazard = (rs1 != '0 && busy[rs1] && !(wr_en && a3 == rs1)) ||
                  (rs2 != '0 && busy[rs2] && !(wr_en && a3 == rs2));
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign acc      = in_valid && in_ready;
  always_comb begin
    imm32 = ImmControl == 3'd0 ? {{20{instr[31]}}, instr[31:20]} :
            ImmControl == 3'd1 ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            ImmControl == 3'd2 ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            ImmControl == 3'd3 ? {instr[31:12], 12'b0} :
            ImmControl == 3'd4 ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            ImmControl == 3'd5 ? {27'b0, instr[19:15]} : 32'b0;
    imm   = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end
  // set is applied after clear so a same-index collision leaves the bit set
  assign busy_nxt = (busy & ~(NREGS'(wr_en) << a3)) |
                    (NREGS'(acc && in_rd_we && rd != '0) << rd);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy      <= '0;
      out_valid <= 1'b0;
      rd1       <= '0;
      rd2       <= '0;
      ImmOp     <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
    end else begin
      if (wr_en) regs[a3] <= wd3;
      busy <= busy_nxt;
      if (acc) begin
        out_valid <= 1'b1;
        rd1       <= op1;
        rd2       <= op2;
        ImmOp     <= imm;
        out_rd    <= rd;
        out_rd_we <= in_rd_we && rd != '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
